// File: rtl/traffic_light_pkg.sv
// Shared definitions for the pedestrian-crossing traffic light controller:
// state encoding, default dwell times and timer sizing helpers.
package traffic_light_pkg;

    // Vehicle phase; the fourth encoding (2'b11) is unreachable and recovers to S_GREEN.
    typedef enum logic [1:0] {
        S_GREEN  = 2'b00,
        S_YELLOW = 2'b01,
        S_RED    = 2'b10
    } tlc_state_e;

    // Default dwell times in clk cycles.
    localparam int GREEN_MIN_DEFAULT   = 4;
    localparam int YELLOW_TIME_DEFAULT = 2;
    localparam int WALK_TIME_DEFAULT   = 4;

    // Largest of three dwell times.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

    // Dwell timer width: enough bits to hold the longest dwell, plus one.
    function automatic int timer_width(input int g, input int y, input int w);
        return $clog2(max3(g, y, w)) + 1;
    endfunction

endpackage

// File: rtl/tlc_dwell_timer.sv
// Saturating dwell counter: cleared on a phase change, otherwise counts
// cycles spent in the current phase and sticks at its maximum value.
module tlc_dwell_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         enable,
    output logic [W-1:0] count
);

    // Count up while enabled, restart on clear, hold once all ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/traffic_light_controler.sv
// Pedestrian-crossing traffic light controller. A Moore FSM cycles
// GREEN -> YELLOW -> RED(walk) -> GREEN; green is held until a pedestrian
// request is seen and the minimum green time has elapsed.
module traffic_light_controler
    import traffic_light_pkg::*;
#(
    parameter int GREEN_MIN   = GREEN_MIN_DEFAULT,
    parameter int YELLOW_TIME = YELLOW_TIME_DEFAULT,
    parameter int WALK_TIME   = WALK_TIME_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic pedestrian_btn,
    output logic red,
    output logic yellow,
    output logic green,
    output logic walk_light,
    output logic stop_light
);

    localparam int TW = timer_width(GREEN_MIN, YELLOW_TIME, WALK_TIME);

    // Timer value seen in the last cycle of each phase (timer starts at 0).
    localparam logic [TW-1:0] GREEN_LAST  = TW'(GREEN_MIN - 1);
    localparam logic [TW-1:0] YELLOW_LAST = TW'(YELLOW_TIME - 1);
    localparam logic [TW-1:0] WALK_LAST   = TW'(WALK_TIME - 1);

    tlc_state_e    state;
    tlc_state_e    state_next;
    logic [TW-1:0] timer;
    logic          state_change;
    logic          leave_green;
    logic          req_pending;

    // State register; reset forces the green phase immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_GREEN;
        end else begin
            state <= state_next;
        end
    end

    // Next-state selection and lamp decode from the current state only.
    always_comb begin
        state_next  = state;
        leave_green = 1'b0;
        red         = 1'b0;
        yellow      = 1'b0;
        green       = 1'b0;
        walk_light  = 1'b0;
        stop_light  = 1'b0;
        case (state)
            S_GREEN: begin
                green      = 1'b1;
                stop_light = 1'b1;
                // A live press counts as well as a latched one, giving
                // one-cycle response once minimum green has elapsed.
                if ((timer >= GREEN_LAST) && (req_pending || pedestrian_btn)) begin
                    state_next  = S_YELLOW;
                    leave_green = 1'b1;
                end
            end
            S_YELLOW: begin
                yellow     = 1'b1;
                stop_light = 1'b1;
                if (timer >= YELLOW_LAST) begin
                    state_next = S_RED;
                end
            end
            S_RED: begin
                red        = 1'b1;
                walk_light = 1'b1;
                if (timer >= WALK_LAST) begin
                    state_next = S_GREEN;
                end
            end
            default: begin
                // Unused encoding: show the safe green/don't-walk lamps and
                // return to S_GREEN on the next edge.
                green      = 1'b1;
                stop_light = 1'b1;
                state_next = S_GREEN;
            end
        endcase
    end

    assign state_change = (state_next != state);

    // Latch pedestrian presses seen during green; cleared when green is left.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_pending <= 1'b0;
        end else if (leave_green) begin
            req_pending <= 1'b0;
        end else if ((state == S_GREEN) && pedestrian_btn) begin
            req_pending <= 1'b1;
        end
    end

    tlc_dwell_timer #(
        .W(TW)
    ) u_dwell_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (state_change),
        .enable(1'b1),
        .count (timer)
    );

endmodule

// File: tb/tb_traffic_light_controler.sv
// Self-checking bench for traffic_light_controler: directed scenarios and
// randomized presses compared against a timeline model of the light sequence.
module tb_traffic_light_controler;

    localparam int GM = 4;
    localparam int YT = 2;
    localparam int WT = 4;

    // Lamp vector order: {red, yellow, green, walk_light, stop_light}
    localparam logic [4:0] LAMP_G = 5'b00101;
    localparam logic [4:0] LAMP_Y = 5'b01001;
    localparam logic [4:0] LAMP_R = 5'b10010;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic pedestrian_btn = 1'b0;
    logic red, yellow, green, walk_light, stop_light;

    int compared = 0;
    int mismatched = 0;

    // Timeline model state
    int m_cyc;
    int m_green_start;
    int m_seq_start;
    bit m_pending;

    traffic_light_controler #(
        .GREEN_MIN  (GM),
        .YELLOW_TIME(YT),
        .WALK_TIME  (WT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pedestrian_btn(pedestrian_btn),
        .red           (red),
        .yellow        (yellow),
        .green         (green),
        .walk_light    (walk_light),
        .stop_light    (stop_light)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] lamps();
        return {red, yellow, green, walk_light, stop_light};
    endfunction

    task automatic model_reset();
        m_cyc         = 0;
        m_green_start = 0;
        m_seq_start   = -1;
        m_pending     = 1'b0;
    endtask

    // Expected lamps for the current cycle given the button level in it,
    // then advance the timeline by one cycle.
    task automatic model_step(input logic b, output logic [4:0] exp);
        int rel;
        bit in_green;
        in_green = 1'b1;
        exp = LAMP_G;
        if (m_seq_start >= 0) begin
            rel = m_cyc - m_seq_start;
            if (rel < YT) begin
                exp = LAMP_Y;
                in_green = 1'b0;
            end else if (rel < YT + WT) begin
                exp = LAMP_R;
                in_green = 1'b0;
            end else begin
                m_seq_start   = -1;
                m_green_start = m_cyc;
            end
        end
        if (in_green) begin
            exp = LAMP_G;
            if (b) m_pending = 1'b1;
            if (m_pending && (m_cyc - m_green_start >= GM - 1)) begin
                m_seq_start = m_cyc + 1;
                m_pending   = 1'b0;
            end
        end
        m_cyc++;
    endtask

    // Pulse reset away from clock edges; released 1 ns after a rising edge.
    task automatic do_reset();
        pedestrian_btn = 1'b0;
        @(negedge clk);
        #1 rst = 1'b1;
        #5 rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        logic [4:0] exp;
        logic [4:0] obs;
        #2 rst = 1'b1;
        #1;
        obs = lamps();
        compared++;
        if (obs !== LAMP_G) begin
            mismatched++;
            $display("FAIL reset_async lamps=%b required=%b", obs, LAMP_G);
        end
        #4 rst = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            obs = lamps();
            model_step(1'b0, exp);
            compared++;
            if (obs !== exp) begin
                mismatched++;
                $display("FAIL reset_after c%0d lamps=%b required=%b", i, obs, exp);
            end
        end
    endtask

    task automatic test_idle();
        logic [4:0] exp;
        logic [4:0] obs;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            obs = lamps();
            model_step(1'b0, exp);
            compared++;
            if (obs !== exp || obs !== LAMP_G) begin
                mismatched++;
                $display("FAIL idle c%0d lamps=%b required=%b", i, obs, LAMP_G);
            end
        end
    endtask

    task automatic test_early_press();
        logic [4:0] exp;
        logic [4:0] obs;
        logic [4:0] want;
        logic b;
        do_reset();
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            obs = lamps();
            b = (c == 1);
            model_step(b, exp);
            if (c <= 3)      want = LAMP_G;
            else if (c <= 5) want = LAMP_Y;
            else if (c <= 9) want = LAMP_R;
            else             want = LAMP_G;
            compared++;
            if (obs !== exp || obs !== want) begin
                mismatched++;
                $display("FAIL early_press c%0d lamps=%b required=%b", c, obs, want);
            end
            pedestrian_btn = b;
        end
        pedestrian_btn = 1'b0;
    endtask

    task automatic test_late_press();
        logic [4:0] exp;
        logic [4:0] obs;
        logic [4:0] want;
        logic b;
        do_reset();
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            obs = lamps();
            b = (c >= 8 && c <= 12);
            model_step(b, exp);
            if (c <= 8)       want = LAMP_G;
            else if (c <= 10) want = LAMP_Y;
            else if (c <= 14) want = LAMP_R;
            else              want = LAMP_G;
            compared++;
            if (obs !== exp || obs !== want) begin
                mismatched++;
                $display("FAIL late_press c%0d lamps=%b required=%b", c, obs, want);
            end
            pedestrian_btn = b;
        end
        pedestrian_btn = 1'b0;
    endtask

    task automatic test_ignore_presses();
        logic [4:0] exp;
        logic [4:0] obs;
        logic [4:0] want;
        logic b;
        do_reset();
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            obs = lamps();
            b = (c == 0) || (c >= 4 && c <= 9);
            model_step(b, exp);
            if (c <= 3)      want = LAMP_G;
            else if (c <= 5) want = LAMP_Y;
            else if (c <= 9) want = LAMP_R;
            else             want = LAMP_G;
            compared++;
            if (obs !== exp || obs !== want) begin
                mismatched++;
                $display("FAIL ignore_press c%0d lamps=%b required=%b", c, obs, want);
            end
            pedestrian_btn = b;
        end
        pedestrian_btn = 1'b0;
    endtask

    task automatic test_async_reset();
        logic [4:0] exp;
        logic [4:0] obs;
        logic b;
        // Abort during the second walk cycle (cycle 7).
        do_reset();
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            obs = lamps();
            b = (c == 0);
            model_step(b, exp);
            compared++;
            if (obs !== exp) begin
                mismatched++;
                $display("FAIL async_pre c%0d lamps=%b required=%b", c, obs, exp);
            end
            pedestrian_btn = b;
        end
        pedestrian_btn = 1'b0;
        #1 rst = 1'b1;
        #1;
        obs = lamps();
        compared++;
        if (obs !== LAMP_G) begin
            mismatched++;
            $display("FAIL async_walk_abort lamps=%b required=%b", obs, LAMP_G);
        end
        #4 rst = 1'b0;
        model_reset();
        // Press latched, then reset before it is serviced: must be discarded.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            obs = lamps();
            b = (c == 1);
            model_step(b, exp);
            compared++;
            if (obs !== exp) begin
                mismatched++;
                $display("FAIL async_pend c%0d lamps=%b required=%b", c, obs, exp);
            end
            pedestrian_btn = b;
        end
        pedestrian_btn = 1'b0;
        #1 rst = 1'b1;
        #5 rst = 1'b0;
        model_reset();
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            obs = lamps();
            model_step(1'b0, exp);
            compared++;
            if (obs !== exp || obs !== LAMP_G) begin
                mismatched++;
                $display("FAIL async_discard c%0d lamps=%b required=%b", c, obs, LAMP_G);
            end
        end
    endtask

    task automatic test_random();
        logic [4:0] exp;
        logic [4:0] obs;
        logic b;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            obs = lamps();
            b = ($urandom_range(0, 3) == 0);
            model_step(b, exp);
            compared++;
            if (obs !== exp) begin
                mismatched++;
                $display("FAIL random c%0d lamps=%b required=%b", c, obs, exp);
            end
            compared++;
            if ($countones({red, yellow, green}) != 1 || walk_light !== ~stop_light
                || walk_light !== red) begin
                mismatched++;
                $display("FAIL invariant c%0d lamps=%b required one-hot vehicle, walk=red=~stop",
                         c, obs);
            end
            pedestrian_btn = b;
        end
        pedestrian_btn = 1'b0;
    endtask

    initial begin
        test_reset();
        test_idle();
        test_early_press();
        test_late_press();
        test_ignore_presses();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/traffic_light_controler.md
TRAFFIC_LIGHT_CONTROLER -- requirements
Module: traffic_light_controler

Interface
REQ-001 SHALL provide parameter GREEN_MIN, default 4, minimum vehicle-green dwell in clk cycles (>=1).
REQ-002 SHALL provide parameter YELLOW_TIME, default 2, vehicle-yellow dwell in clk cycles (>=1).
REQ-003 SHALL provide parameter WALK_TIME, default 4, vehicle-red/pedestrian-walk dwell in clk cycles (>=1).
REQ-004 SHALL have one clock and an asynchronous, active-high reset, with ports as follows.
REQ-005 clk  input  1  system clock, rising-edge active.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 pedestrian_btn  input  1  pedestrian crossing request, level sampled on each rising clk edge, assumed synchronous.
REQ-008 red  output  1  vehicle red lamp.
REQ-009 yellow  output  1  vehicle yellow lamp.
REQ-010 green  output  1  vehicle green lamp.
REQ-011 walk_light  output  1  pedestrian WALK lamp.
REQ-012 stop_light  output  1  pedestrian DON'T-WALK lamp.

Function
REQ-013 SHALL implement a Moore FSM with states S_GREEN, S_YELLOW, S_RED; all outputs decoded from the state register only.
REQ-014 S_GREEN: green=1, stop_light=1, all others 0.
REQ-015 S_YELLOW: yellow=1, stop_light=1, all others 0.
REQ-016 S_RED: red=1, walk_light=1, all others 0.
REQ-017 Exactly one vehicle lamp and exactly one pedestrian lamp SHALL be high in every cycle; walk_light=1 only when red=1.
REQ-018 Dwell timer SHALL clear to 0 on every state change, increment once per cycle while in a state, and saturate at its maximum (width = clog2 of the largest parameter, plus 1).
REQ-019 req_pending flag SHALL set on any rising edge in S_GREEN where pedestrian_btn=1; it holds until cleared.
REQ-020 S_GREEN -> S_YELLOW SHALL occur on the rising edge where timer >= GREEN_MIN-1 and (req_pending | pedestrian_btn); green therefore lasts at least GREEN_MIN cycles.
REQ-021 Without any request, the FSM SHALL remain in S_GREEN indefinitely.
REQ-022 A request arriving after GREEN_MIN has elapsed SHALL cause S_YELLOW on that same edge (one-cycle latency).
REQ-023 A single-cycle press before GREEN_MIN has elapsed SHALL be retained via req_pending and serviced once the minimum green expires.
REQ-024 S_YELLOW -> S_RED SHALL occur after exactly YELLOW_TIME cycles in S_YELLOW.
REQ-025 S_RED -> S_GREEN SHALL occur after exactly WALK_TIME cycles in S_RED.
REQ-026 req_pending SHALL clear on the S_GREEN -> S_YELLOW edge.
REQ-027 Presses during S_YELLOW or S_RED SHALL be ignored and SHALL NOT extend or repeat the cycle.
REQ-028 Any unreachable state encoding SHALL recover to S_GREEN on the next edge.

Reset
REQ-029 When rst=1, the FSM SHALL immediately (asynchronously) enter S_GREEN, with timer=0 and req_pending=0.
REQ-030 Outputs during and after reset SHALL be green=1, stop_light=1, red=yellow=walk_light=0.
REQ-031 Reset asserted mid-cycle, including during S_RED walk, SHALL abort the sequence and discard any pending request.

Structure
REQ-032 State encoding and default timing constants SHALL live in a shared package, traffic_light_pkg.
REQ-033 The dwell counter SHALL be a separate sub-module, tlc_dwell_timer, with inputs clear and enable and a count output.

Verification
REQ-034 Reset for 5 ns, no button for 20 cycles -> green=1 and stop_light=1 throughout; no other lamp rises.
REQ-035 One-cycle press at cycle 1 after reset -> green through cycle 3, yellow for cycles 4-5, red+walk for cycles 6-9, green from cycle 10.
REQ-036 Press held at cycle 8 of green -> yellow from the next cycle, then 2 yellow cycles, then 4 walk cycles.
REQ-037 Presses during yellow and walk -> exactly one yellow/walk sequence, then green persists with no second cycle.
REQ-038 rst asserted at the 2nd walk cycle -> immediate green=1, stop_light=1, walk_light=0, with no clock edge required.
REQ-039 Every cycle of every test -> exactly one of red/yellow/green is high, and walk_light equals ~stop_light equals red.
